// File: rtl/weight_tile_scheduler_pkg.sv
// rtl/weight_tile_scheduler_pkg.sv - shared widths and state encoding for the weight tile scheduler
package weight_tile_scheduler_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int CNT_W_DEF  = 17;
  localparam int TILE_W_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_HANDOFF = 3'd3,
    ST_DONE    = 3'd4
  } sched_state_t;

endpackage

// File: rtl/weight_tile_scheduler.sv
// rtl/weight_tile_scheduler.sv - sequences weight tiles through the loader and hands them to compute
module weight_tile_scheduler
  import weight_tile_scheduler_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TILE_W = TILE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [CNT_W-1:0]  cfg_tile_words,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  input  logic              abort,
  output logic              ld_start,
  output logic [ADDR_W-1:0] ld_base_addr,
  output logic [CNT_W-1:0]  ld_load_count,
  input  logic              ld_done,
  output logic              tile_valid,
  output logic [TILE_W-1:0] tile_idx,
  input  logic              compute_done,
  output logic              busy,
  output logic              layer_done,
  output logic              cfg_err
);

  sched_state_t      state_q, state_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
  logic [ADDR_W-1:0] acc_q, acc_d;
  logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
  logic              abort_q, abort_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              ld_start_q, ld_start_d;
  logic [ADDR_W-1:0] ld_base_addr_q, ld_base_addr_d;
  logic [CNT_W-1:0]  ld_load_count_q, ld_load_count_d;
  logic              tile_valid_q, tile_valid_d;
  logic              busy_q, busy_d;
  logic              layer_done_q, layer_done_d;
  logic              cfg_err_q, cfg_err_d;
  logic              last_tile;

  assign last_tile = (tile_idx_q == num_tiles_q - TILE_W'(1));

  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    words_d     = words_q;
    num_tiles_d = num_tiles_q;
    acc_d       = acc_q;
    tile_idx_d  = tile_idx_q;
    abort_d     = abort_q;
    cfg_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          if (cfg_num_tiles == '0 || cfg_tile_words == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            stride_d    = cfg_stride;
            words_d     = cfg_tile_words;
            num_tiles_d = cfg_num_tiles;
            acc_d       = cfg_base;
            tile_idx_d  = '0;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = abort ? ST_IDLE : ST_LOAD;
      end
      ST_LOAD: begin
        // The loader cannot be interrupted, so an abort waits here for its ld_done.
        if (ld_done) begin
          state_d = (abort || abort_q) ? ST_IDLE : ST_HANDOFF;
          abort_d = 1'b0;
        end else if (abort) begin
          abort_d = 1'b1;
        end
      end
      ST_HANDOFF: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (compute_done) begin
          if (last_tile) begin
            state_d = ST_DONE;
          end else begin
            tile_idx_d = tile_idx_q + TILE_W'(1);
            acc_d      = acc_q + stride_q;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered images of the state being entered.
    cfg_ready_d     = (state_d == ST_IDLE);
    busy_d          = (state_d != ST_IDLE);
    ld_start_d      = (state_d == ST_ISSUE);
    tile_valid_d    = (state_d == ST_HANDOFF);
    layer_done_d    = (state_d == ST_DONE);
    ld_base_addr_d  = (state_d == ST_ISSUE) ? acc_d : ld_base_addr_q;
    ld_load_count_d = (state_d == ST_ISSUE) ? words_d : ld_load_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      stride_q        <= '0;
      words_q         <= '0;
      num_tiles_q     <= '0;
      acc_q           <= '0;
      tile_idx_q      <= '0;
      abort_q         <= 1'b0;
      cfg_ready_q     <= 1'b1;
      ld_start_q      <= 1'b0;
      ld_base_addr_q  <= '0;
      ld_load_count_q <= '0;
      tile_valid_q    <= 1'b0;
      busy_q          <= 1'b0;
      layer_done_q    <= 1'b0;
      cfg_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      stride_q        <= stride_d;
      words_q         <= words_d;
      num_tiles_q     <= num_tiles_d;
      acc_q           <= acc_d;
      tile_idx_q      <= tile_idx_d;
      abort_q         <= abort_d;
      cfg_ready_q     <= cfg_ready_d;
      ld_start_q      <= ld_start_d;
      ld_base_addr_q  <= ld_base_addr_d;
      ld_load_count_q <= ld_load_count_d;
      tile_valid_q    <= tile_valid_d;
      busy_q          <= busy_d;
      layer_done_q    <= layer_done_d;
      cfg_err_q       <= cfg_err_d;
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign ld_start      = ld_start_q;
  assign ld_base_addr  = ld_base_addr_q;
  assign ld_load_count = ld_load_count_q;
  assign tile_valid    = tile_valid_q;
  assign tile_idx      = tile_idx_q;
  assign busy          = busy_q;
  assign layer_done    = layer_done_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_weight_tile_scheduler.sv
// tb/tb_weight_tile_scheduler.sv - directed and randomized layer sequences against a tile address model
module tb_weight_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [18:0] cfg_base;
  logic [18:0] cfg_stride;
  logic [16:0] cfg_tile_words;
  logic [11:0] cfg_num_tiles;
  logic        abort;
  logic        ld_start;
  logic [18:0] ld_base_addr;
  logic [16:0] ld_load_count;
  logic        ld_done;
  logic        tile_valid;
  logic [11:0] tile_idx;
  logic        compute_done;
  logic        busy;
  logic        layer_done;
  logic        cfg_err;

  int total = 0;
  int bad   = 0;

  weight_tile_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_base       (cfg_base),
    .cfg_stride     (cfg_stride),
    .cfg_tile_words (cfg_tile_words),
    .cfg_num_tiles  (cfg_num_tiles),
    .abort          (abort),
    .ld_start       (ld_start),
    .ld_base_addr   (ld_base_addr),
    .ld_load_count  (ld_load_count),
    .ld_done        (ld_done),
    .tile_valid     (tile_valid),
    .tile_idx       (tile_idx),
    .compute_done   (compute_done),
    .busy           (busy),
    .layer_done     (layer_done),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [18:0] base, input logic [18:0] stride,
                         input logic [16:0] words, input logic [11:0] tiles);
    cfg_base       = base;
    cfg_stride     = stride;
    cfg_tile_words = words;
    cfg_num_tiles  = tiles;
  endtask

  // Tile i of a layer lives at base + i*stride, truncated to the 19-bit address space.
  task automatic run_layer(input logic [18:0] base, input logic [18:0] stride,
                           input logic [16:0] words, input logic [11:0] tiles,
                           input int dmax, input bit spur);
    int d;
    logic [18:0] ea;
    chk1("idle_ready", cfg_ready, 1'b1);
    set_cfg(base, stride, words, tiles);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < int'(tiles); i++) begin
      ea = base + 19'(i) * stride;
      chk1("ld_start_on", ld_start, 1'b1);
      chk32("ld_base_addr", 32'(ld_base_addr), 32'(ea));
      chk32("ld_load_count", 32'(ld_load_count), 32'(words));
      chk1("busy_on", busy, 1'b1);
      chk1("ready_low", cfg_ready, 1'b0);
      step();
      chk1("ld_start_once", ld_start, 1'b0);
      d = (dmax == 0) ? 0 : int'($urandom_range(dmax, 0));
      compute_done = spur;
      repeat (d) begin
        step();
        chk1("no_tv_in_load", tile_valid, 1'b0);
        chk1("no_restart_load", ld_start, 1'b0);
      end
      compute_done = 1'b0;
      ld_done = 1'b1;
      step();
      ld_done = 1'b0;
      chk1("tv_rise", tile_valid, 1'b1);
      chk32("tile_idx", 32'(tile_idx), 32'(i));
      d = (dmax == 0) ? 0 : int'($urandom_range(dmax, 0));
      ld_done   = spur;
      cfg_valid = spur;
      repeat (d) begin
        step();
        chk1("tv_hold", tile_valid, 1'b1);
        chk32("idx_hold", 32'(tile_idx), 32'(i));
        chk1("ready_hold", cfg_ready, 1'b0);
        chk1("no_start_handoff", ld_start, 1'b0);
      end
      ld_done      = 1'b0;
      cfg_valid    = 1'b0;
      compute_done = 1'b1;
      step();
      compute_done = 1'b0;
      chk1("tv_fall", tile_valid, 1'b0);
      if (i == int'(tiles) - 1) begin
        chk1("layer_done", layer_done, 1'b1);
        chk1("ready_c1", cfg_ready, 1'b0);
        step();
        chk1("layer_done_once", layer_done, 1'b0);
        chk1("ready_c2", cfg_ready, 1'b1);
        chk1("busy_idle", busy, 1'b0);
      end else begin
        chk1("no_early_layer_done", layer_done, 1'b0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    abort = 1'b0;
    ld_done = 1'b0;
    compute_done = 1'b0;
    set_cfg(19'h0, 19'h0, 17'h0, 12'h0);
    step();
    step();
    rst = 1'b0;
    step();

    chk1("rst_cfg_ready", cfg_ready, 1'b1);
    chk1("rst_ld_start", ld_start, 1'b0);
    chk1("rst_tile_valid", tile_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_layer_done", layer_done, 1'b0);
    chk1("rst_cfg_err", cfg_err, 1'b0);
    chk32("rst_ld_base_addr", 32'(ld_base_addr), 32'h0);
    chk32("rst_ld_load_count", 32'(ld_load_count), 32'h0);
    chk32("rst_tile_idx", 32'(tile_idx), 32'h0);

    run_layer(19'h00100, 19'h00040, 17'd64, 12'd3, 0, 1'b0);

    set_cfg(19'h00100, 19'h00040, 17'd64, 12'd0);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk1("err_tiles0", cfg_err, 1'b1);
    chk1("err_tiles0_no_start", ld_start, 1'b0);
    chk1("err_tiles0_busy", busy, 1'b0);
    chk1("err_tiles0_ready", cfg_ready, 1'b1);
    step();
    chk1("err_tiles0_pulse", cfg_err, 1'b0);
    chk1("err_tiles0_no_start2", ld_start, 1'b0);
    set_cfg(19'h00100, 19'h00040, 17'd0, 12'd3);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk1("err_words0", cfg_err, 1'b1);
    chk1("err_words0_no_start", ld_start, 1'b0);
    chk1("err_words0_busy", busy, 1'b0);
    step();
    chk1("err_words0_pulse", cfg_err, 1'b0);
    chk1("err_words0_busy2", busy, 1'b0);

    run_layer(19'h7FFC0, 19'h00080, 17'd16, 12'd2, 2, 1'b0);

    run_layer(19'h01000, 19'h00020, 17'd5, 12'd2, 3, 1'b1);

    set_cfg(19'h00200, 19'h00010, 17'd8, 12'd4);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    compute_done = 1'b1;
    step();
    compute_done = 1'b0;
    chk1("ab_issue_t1", ld_start, 1'b1);
    chk32("ab_addr_t1", 32'(ld_base_addr), 32'h210);
    chk32("ab_idx_t1", 32'(tile_idx), 32'd1);
    step();
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (9) begin
      step();
      chk1("ab_wait_no_tv", tile_valid, 1'b0);
      chk1("ab_wait_busy", busy, 1'b1);
    end
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    chk1("ab_no_tv", tile_valid, 1'b0);
    chk1("ab_idle_busy", busy, 1'b0);
    chk1("ab_idle_ready", cfg_ready, 1'b1);
    chk1("ab_no_layer_done", layer_done, 1'b0);
    repeat (3) begin
      step();
      chk1("ab_no_more_start", ld_start, 1'b0);
      chk1("ab_no_more_done", layer_done, 1'b0);
    end

    set_cfg(19'h00300, 19'h00010, 17'd4, 12'd1);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    chk1("abcd_tv", tile_valid, 1'b1);
    abort = 1'b1;
    compute_done = 1'b1;
    step();
    abort = 1'b0;
    compute_done = 1'b0;
    chk1("abcd_no_layer_done", layer_done, 1'b0);
    chk1("abcd_tv_low", tile_valid, 1'b0);
    chk1("abcd_idle", busy, 1'b0);
    step();
    chk1("abcd_no_layer_done2", layer_done, 1'b0);
    chk1("abcd_no_start", ld_start, 1'b0);

    set_cfg(19'h00400, 19'h00010, 17'd4, 12'd3);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    rst = 1'b1;
    #1;
    chk1("mrst_tv", tile_valid, 1'b0);
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_ready", cfg_ready, 1'b1);
    chk32("mrst_addr", 32'(ld_base_addr), 32'h0);
    step();
    rst = 1'b0;
    step();
    chk1("mrst_no_layer_done", layer_done, 1'b0);
    chk1("mrst_no_start", ld_start, 1'b0);

    for (int k = 0; k < 6; k++) begin
      run_layer(19'($urandom), 19'($urandom), 17'($urandom_range(17'h1FFFF, 1)),
                12'($urandom_range(5, 1)), 4, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
